// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int BEAT_CNT_W = 8;

    // Index/counter width that stays at least one bit for tiny ranges.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port signals; master = arbiter side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    import fifo_arb_pkg::*;

    localparam int GRANT_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          write_enable;
    logic                          wfull;
    logic                          wr_almost_ful;
    logic [ADDRESS_WIDTH:0]        wr_level;
    logic                          overflow;
    logic [GRANT_W-1:0]            grant_id;
    logic                          busy;
    logic                          ovf_err;

    modport master (
        input  req_valid, req_data, req_last, wfull, wr_almost_ful, wr_level, overflow,
        output req_ready, wdata, write_enable, grant_id, busy, ovf_err
    );

    modport slave (
        output req_valid, req_data, req_last, wfull, wr_almost_ful, wr_level, overflow,
        input  req_ready, wdata, write_enable, grant_id, busy, ovf_err
    );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [PTR_W-1:0]   pick
);

    localparam logic [PTR_W:0] NUM_V = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    assign any_req = |req;

    // Scan farthest offset first so the nearest valid index wins.
    always_comb begin
        pick = rr_ptr;
        sum  = '0;
        idx  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (sum >= NUM_V) begin
                sum = sum - NUM_V;
            end
            idx = sum[PTR_W-1:0];
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of async_fifo_int_mem.
// state     | meaning
// ARB_IDLE  | no grant held; arbitrate among valid requesters (one-cycle bubble)
// ARB_BURST | grant_id owns the write port until last beat, burst cap or stall timeout
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int MAX_BURST     = 8,
    parameter int AFULL_GATE    = 1,
    parameter int STALL_TIMEOUT = 16
) (
    input  logic              wclk,
    input  logic              sw_rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int GW    = idx_width(NUM_REQ);
    localparam int SW    = idx_width(STALL_TIMEOUT);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH+1:0] DEPTH_V     = (ADDRESS_WIDTH+2)'(DEPTH);
    localparam logic [BEAT_CNT_W-1:0]    LAST_BEAT   = BEAT_CNT_W'(MAX_BURST - 1);
    localparam logic [SW-1:0]            STALL_LIMIT = SW'(STALL_TIMEOUT - 1);
    localparam logic [GW-1:0]            LAST_PTR    = GW'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    write_enable_q, write_enable_d;
    logic                    ovf_err_q, ovf_err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]           stall_cnt_q, stall_cnt_d;

    logic                    any_req;
    logic [GW-1:0]           pick;
    logic [ADDRESS_WIDTH+1:0] level_sum;
    logic                    space_ok;
    logic                    own_valid;
    logic                    own_last;
    logic [DATA_WIDTH-1:0]   own_data;
    logic                    accept;
    logic                    gate_ok;
    logic [GW-1:0]           next_ptr;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GW)
    ) u_pick (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr_q),
        .any_req (any_req),
        .pick    (pick)
    );

    // The registered write_enable is the beat the FIFO has not counted yet.
    assign level_sum = {1'b0, bus.wr_level} + {{(ADDRESS_WIDTH+1){1'b0}}, write_enable_q};
    assign space_ok  = !bus.wfull && (level_sum < DEPTH_V);
    assign own_valid = bus.req_valid[grant_id_q];
    assign own_last  = bus.req_last[grant_id_q];
    assign own_data  = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign accept    = (state_q == ARB_BURST) && own_valid && space_ok;
    assign gate_ok   = (AFULL_GATE == 0) || !bus.wr_almost_ful;
    assign next_ptr  = (grant_id_q == LAST_PTR) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (state_q == ARB_BURST) begin
            bus.req_ready[grant_id_q] = space_ok;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        busy_d         = busy_q;
        write_enable_d = 1'b0;
        wdata_d        = wdata_q;
        beat_cnt_d     = beat_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        ovf_err_d      = ovf_err_q | bus.overflow;
        case (state_q)
            ARB_IDLE: begin
                if (any_req && gate_ok) begin
                    state_d     = ARB_BURST;
                    grant_id_d  = pick;
                    busy_d      = 1'b1;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                if (accept) begin
                    write_enable_d = 1'b1;
                    wdata_d        = own_data;
                    beat_cnt_d     = beat_cnt_q + 1'b1;
                    stall_cnt_d    = '0;
                    if (own_last || (beat_cnt_q == LAST_BEAT)) begin
                        state_d  = ARB_IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!own_valid) begin
                    // Waiting on FIFO space is not a stall; only an absent requester is.
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if ((STALL_TIMEOUT != 0) && (stall_cnt_q == STALL_LIMIT)) begin
                        state_d  = ARB_IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (sw_rst) begin
            state_q        <= ARB_IDLE;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            busy_q         <= 1'b0;
            write_enable_q <= 1'b0;
            wdata_q        <= '0;
            beat_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            ovf_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            busy_q         <= busy_d;
            write_enable_q <= write_enable_d;
            wdata_q        <= wdata_d;
            beat_cnt_q     <= beat_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            ovf_err_q      <= ovf_err_d;
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.wdata        = wdata_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;
    assign bus.ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a per-cycle behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int MB    = 8;
    localparam int AG    = 1;
    localparam int TO    = 16;
    localparam int DEPTH = 1 << AW;

    logic wclk = 1'b0;
    logic sw_rst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .MAX_BURST(MB), .AFULL_GATE(AG), .STALL_TIMEOUT(TO)
    ) dut (
        .wclk   (wclk),
        .sw_rst (sw_rst),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester beat queues: bit DW is the last flag.
    logic [DW:0]    bq [NR][$];
    logic [NR-1:0]  acc_s = '0;

    always @(negedge wclk) acc_s = bus.req_valid & bus.req_ready;

    initial begin
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge wclk);
            #2;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < NR; i++) begin
                if (acc_s[i] && bq[i].size() > 0) void'(bq[i].pop_front());
                if (bq[i].size() > 0) begin
                    v[i] = 1'b1;
                    l[i] = bq[i][0][DW];
                    d[i*DW +: DW] = bq[i][0][DW-1:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Behavioural model: owner < 0 means no grant held.
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_beats = 0;
    int          m_stall = 0;
    bit          m_we    = 0;
    bit          m_ovf   = 0;
    logic [DW-1:0] m_wdata = '0;

    function automatic bit m_space();
        return !bus.wfull && ((int'(bus.wr_level) + int'(m_we)) < DEPTH);
    endfunction

    always @(posedge wclk) begin
        bit sp;
        bit nwe;
        int idx;
        if (sw_rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_stall = 0;
            m_we = 0; m_ovf = 0; m_wdata = '0;
        end else begin
            sp  = m_space();
            nwe = 0;
            if (bus.overflow) m_ovf = 1;
            if (m_owner < 0) begin
                if (bus.req_valid != 0 && !(AG != 0 && bus.wr_almost_ful)) begin
                    for (int i = 0; i < NR; i++) begin
                        idx = (m_ptr + i) % NR;
                        if (m_owner < 0 && bus.req_valid[idx]) m_owner = idx;
                    end
                    m_beats = 0;
                    m_stall = 0;
                end
            end else if (bus.req_valid[m_owner] && sp) begin
                nwe     = 1;
                m_wdata = bus.req_data[m_owner*DW +: DW];
                m_beats++;
                m_stall = 0;
                if (bus.req_last[m_owner] || m_beats == MB) begin
                    m_ptr   = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end else if (!bus.req_valid[m_owner]) begin
                m_stall++;
                if (TO != 0 && m_stall == TO) begin
                    m_ptr   = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end
            m_we = nwe;
        end
    end

    always @(negedge wclk) begin
        logic [NR-1:0] exp_ready;
        if (cmp_en) begin
            exp_ready = '0;
            if (m_owner >= 0 && m_space()) exp_ready[m_owner] = 1'b1;
            check("write_enable", bus.write_enable, m_we);
            if (m_we) check("wdata", bus.wdata, m_wdata);
            check("busy", bus.busy, (m_owner >= 0));
            if (m_owner >= 0) check("grant_id", bus.grant_id, m_owner);
            check("req_ready", bus.req_ready, exp_ready);
            check("ovf_err", bus.ovf_err, m_ovf);
        end
    end

    // Observation logs for hand-computed sequence checks.
    logic [DW-1:0] wlog [$];
    int            glog [$];
    bit            busy_prev = 0;

    always @(negedge wclk) begin
        if (bus.write_enable === 1'b1) wlog.push_back(bus.wdata);
        if (bus.busy === 1'b1 && !busy_prev) glog.push_back(int'(bus.grant_id));
        busy_prev = (bus.busy === 1'b1);
    end

    function automatic logic [DW-1:0] wget(input int k);
        return (k < wlog.size()) ? wlog[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic int gget(input int k);
        return (k < glog.size()) ? glog[k] : -1;
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete();
        glog.delete();
    endtask

    task automatic do_reset();
        sw_rst = 1'b1;
        tick();
        tick();
        sw_rst = 1'b0;
        clear_logs();
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input bit last);
        bq[r].push_back({last, d});
    endtask

    task automatic wait_drain(input string name, input int max);
        bit done;
        bit empty;
        done = 0;
        for (int i = 0; i < max; i++) begin
            empty = 1;
            for (int r = 0; r < NR; r++) if (bq[r].size() != 0) empty = 0;
            if (empty && bus.busy === 1'b0 && bus.write_enable === 1'b0) begin
                done = 1;
                break;
            end
            tick();
        end
        check({name, " drain"}, done, 1);
    endtask

    task automatic wait_we(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (bus.write_enable === 1'b1) break;
            tick();
        end
        check({name, " write seen"}, bus.write_enable, 1);
    endtask

    initial begin
        int nb;
        sw_rst            = 1'b1;
        bus.wfull         = 1'b0;
        bus.wr_almost_ful = 1'b0;
        bus.wr_level      = '0;
        bus.overflow      = 1'b0;
        tick();
        tick();
        check("rst write_enable", bus.write_enable, 0);
        check("rst wdata", bus.wdata, 0);
        check("rst busy", bus.busy, 0);
        check("rst grant_id", bus.grant_id, 0);
        check("rst req_ready", bus.req_ready, 0);
        check("rst ovf_err", bus.ovf_err, 0);
        cmp_en = 1;
        sw_rst = 1'b0;

        // Single requester, three beats.
        push(0, 32'h0000_000A, 0);
        push(0, 32'h0000_000B, 0);
        push(0, 32'h0000_000C, 1);
        wait_drain("single", 50);
        check("single wlog size", wlog.size(), 3);
        check("single beat0", wget(0), 32'h0000_000A);
        check("single beat1", wget(1), 32'h0000_000B);
        check("single beat2", wget(2), 32'h0000_000C);
        check("single grant0", gget(0), 0);

        // Pointer advanced past 0: simultaneous 0 and 1 must grant 1 first.
        clear_logs();
        push(0, 32'h0000_0010, 1);
        push(1, 32'h0000_0011, 1);
        wait_drain("rrptr", 50);
        check("rrptr first", gget(0), 1);
        check("rrptr second", gget(1), 0);

        // Fairness: all four valid, two-beat bursts.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            push(r, 32'h100 * r + 1, 0);
            push(r, 32'h100 * r + 2, 1);
        end
        push(0, 32'h0000_0003, 0);
        push(0, 32'h0000_0004, 1);
        wait_drain("fair", 100);
        check("fair grants", glog.size(), 5);
        check("fair g0", gget(0), 0);
        check("fair g1", gget(1), 1);
        check("fair g2", gget(2), 2);
        check("fair g3", gget(3), 3);
        check("fair g4", gget(4), 0);
        check("fair beats", wlog.size(), 10);

        // Burst cap: req 2 streams 20 beats; 3 and 1 are served between its grants.
        do_reset();
        for (int k = 1; k <= 20; k++) push(2, 32'h2000_0000 + k, (k == 20));
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1) break;
            tick();
        end
        check("cap granted", bus.busy, 1);
        push(3, 32'h0000_3001, 0);
        push(3, 32'h0000_3002, 1);
        push(1, 32'h0000_1001, 0);
        push(1, 32'h0000_1002, 1);
        wait_drain("cap", 200);
        check("cap grants", glog.size(), 5);
        check("cap g0", gget(0), 2);
        check("cap g1", gget(1), 3);
        check("cap g2", gget(2), 1);
        check("cap g3", gget(3), 2);
        check("cap g4", gget(4), 2);
        check("cap beats", wlog.size(), 24);
        check("cap beat8", wget(7), 32'h2000_0008);
        check("cap req3", wget(8), 32'h0000_3001);
        check("cap req1", wget(10), 32'h0000_1001);
        check("cap resume", wget(12), 32'h2000_0009);
        check("cap final", wget(23), 32'h2000_0014);

        // Full boundary: one slot left.
        do_reset();
        bus.wr_level = 6'd31;
        push(0, 32'h0000_00F1, 0);
        push(0, 32'h0000_00F2, 0);
        push(0, 32'h0000_00F3, 1);
        wait_we("full", 20);
        check("full ready low", bus.req_ready, 0);
        tick();
        bus.wr_level = 6'd32;
        repeat (5) tick();
        check("full no write", wlog.size(), 1);
        bus.wr_level = 6'd31;
        tick();
        tick();
        bus.wr_level = '0;
        wait_drain("full", 50);
        check("full beats", wlog.size(), 3);
        check("full beat1", wget(1), 32'h0000_00F2);

        // Almost-full gate.
        do_reset();
        bus.wr_almost_ful = 1'b1;
        push(1, 32'h0000_00A1, 1);
        repeat (5) tick();
        check("afull held", bus.busy, 0);
        bus.wr_almost_ful = 1'b0;
        tick();
        check("afull grant busy", bus.busy, 1);
        check("afull grant id", bus.grant_id, 1);
        wait_drain("afull", 50);

        // Stall timeout: one beat without last, then silence.
        do_reset();
        push(0, 32'h0000_0055, 0);
        wait_we("stall", 20);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy !== 1'b1) break;
            nb++;
            tick();
        end
        check("stall busy cycles", nb, 16);

        // Overflow sticky, then reset mid-burst.
        bus.overflow = 1'b1;
        tick();
        bus.overflow = 1'b0;
        check("ovf set", bus.ovf_err, 1);
        tick();
        check("ovf sticky", bus.ovf_err, 1);
        clear_logs();
        for (int k = 1; k <= 5; k++) push(2, 32'h0000_2200 + k, (k == 5));
        wait_we("rstmid", 20);
        sw_rst = 1'b1;
        tick();
        check("rstmid write_enable", bus.write_enable, 0);
        check("rstmid busy", bus.busy, 0);
        check("rstmid ovf_err", bus.ovf_err, 0);
        sw_rst = 1'b0;
        wait_drain("rstmid", 60);
        check("rstmid beats", wlog.size(), 4);
        check("rstmid dropped", wget(1), 32'h0000_2203);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of async_fifo_int_mem among NUM_REQ requesters in the wclk domain.
- Grants bursts round-robin and drives write_enable/wdata from a registered output stage.
- Tracks FIFO occupancy through wr_level plus the one beat in flight, so it never issues a write the FIFO cannot accept.
- Optionally holds off new bursts while wr_almost_ful is set; latches FIFO overflow as a sticky error.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, FIFO data width.
- ADDRESS_WIDTH, 5, FIFO address width; DEPTH = 1 << ADDRESS_WIDTH.
- MAX_BURST, 8, maximum beats per grant (1..255).
- AFULL_GATE, 1, 1 = no new grant while wr_almost_ful is high.
- STALL_TIMEOUT, 16, idle cycles (valid low) before a held grant is revoked; 0 = never revoke.

Ports:
- wclk  in  1  write-side clock; the block's only clock.
- sw_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester data, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_ready  out  NUM_REQ  beat accepted when valid & ready.
- wdata  out  DATA_WIDTH  to FIFO wdata.
- write_enable  out  1  to FIFO write_enable.
- wfull  in  1  from FIFO.
- wr_almost_ful  in  1  from FIFO.
- wr_level  in  ADDRESS_WIDTH+1  FIFO occupancy (entries).
- overflow  in  1  from FIFO.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy.
- busy  out  1  a grant is held.
- ovf_err  out  1  sticky overflow seen.

Behaviour:
- Reset values (sw_rst=1 at a wclk edge): state=ARB_IDLE, write_enable=0, wdata=0, req_ready=0, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0, stall_cnt=0, ovf_err=0.
- Reset mid-burst drops the grant immediately. A beat accepted in the reset cycle is discarded, never written.
- Space check: space_ok = !wfull && (wr_level + write_enable) < DEPTH. The sum is computed in ADDRESS_WIDTH+2 bits; write_enable here is the registered output, i.e. the beat in flight.
- ARB_IDLE:
  - If any req_valid and (AFULL_GATE==0 or !wr_almost_ful): pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it as grant_id, set busy=1, go to ARB_BURST, clear beat_cnt and stall_cnt.
  - req_ready is 0 in ARB_IDLE. A one-cycle arbitration bubble per burst is required.
- ARB_BURST:
  - req_ready[grant_id] = space_ok; all other req_ready = 0 (combinational from state, grant_id, space_ok).
  - Accept (valid & ready): next edge write_enable=1 and wdata=req_data[grant_id]; beat_cnt++; stall_cnt=0.
  - Otherwise, next edge write_enable=0.
  - Accept with req_last=1 or beat_cnt==MAX_BURST-1: next edge state=ARB_IDLE, busy=0, rr_ptr=(grant_id+1) mod NUM_REQ.
  - req_valid[grant_id]=0: stall_cnt++. If STALL_TIMEOUT!=0 and stall_cnt==STALL_TIMEOUT-1, release as at burst end.
  - Backpressure (space_ok=0) does not count as stall.
- Latency: beat accepted at edge N appears on write_enable/wdata after edge N, so the FIFO samples it at edge N+1.
- Full boundary: at wr_level=DEPTH-1 with write_enable=1, space_ok=0 and no accept. The FIFO therefore never sees a write while full under correct wr_level.
- ovf_err: set at the edge where overflow=1 is sampled; cleared only by sw_rst.
- A requester truncated by MAX_BURST continues its burst at a later grant; its req_last is simply not yet seen.

Decomposition:
- Package fifo_arb_pkg: typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e; localparam function clog2-based width helper.
- Sub-module fifo_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr. Outputs: any_req, pick index.
  - Instantiated once.

Test Plan:
- Reset then single requester: req 0 sends 3 beats A,B,C with last on C; wr_level=0 -> write_enable high 3 cycles with wdata A,B,C; busy drops after C; rr_ptr=1.
- Fairness: all 4 requesters continuously valid with 2-beat bursts -> grant_id sequence 0,1,2,3,0; each burst preceded by one idle cycle.
- Burst cap: req 2 sends 20 beats without last, MAX_BURST=8 -> grant released after beat 8. Other requesters (1,3 valid) are served, then req 2 resumes at beat 9.
- Full boundary: wr_level=31, DEPTH=32, one beat accepted -> req_ready falls the following cycle while write_enable=1. No further write until wr_level drops to 31 with write_enable=0.
- Almost-full gate: wr_almost_ful=1, AFULL_GATE=1, req 1 valid -> stays ARB_IDLE with busy=0; deassert wr_almost_ful -> grant next edge.
- Stall and reset: granted req 0 drops valid for 16 cycles -> grant revoked. Assert sw_rst mid-burst -> write_enable=0, busy=0, ovf_err=0 next edge.
